// File: rtl/alu_pkg.sv
// Shared constants, payload type and instruction decode for the ALU issue stage.
// Decode is a pure function so the issue stage stays a thin wrapper around the buffer.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [5:0] ALUC_ADD  = 6'b100000;
  localparam logic [5:0] ALUC_ADDU = 6'b100001;
  localparam logic [5:0] ALUC_SLT  = 6'b101010;
  localparam logic [5:0] ALUC_SLTU = 6'b101011;
  localparam logic [5:0] ALUC_AND  = 6'b100100;
  localparam logic [5:0] ALUC_OR   = 6'b100101;
  localparam logic [5:0] ALUC_XOR  = 6'b100110;
  localparam logic [5:0] ALUC_LUI  = 6'b001111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  aluc;
    logic [4:0]  dest;
    logic        wr_en;
    logic        ovf_trap_en;
    logic        illegal;
  } alu_pl_t;

  function automatic alu_pl_t alu_decode(input logic [31:0] instr,
                                         input logic [31:0] rs_val,
                                         input logic [31:0] rt_val);
    alu_pl_t     p;
    logic [5:0]  op, fn;
    logic [31:0] sx, zx;
    logic        jr;
    op = instr[31:26];
    fn = instr[5:0];
    sx = {{16{instr[15]}}, instr[15:0]};
    zx = {16'b0, instr[15:0]};
    jr = 1'b0;
    // Anything that falls through keeps the illegal shape: ADDU of zeros, no writeback.
    p = '0;
    p.aluc = ALUC_ADDU;
    p.illegal = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR: begin
            p.illegal = 1'b0;
            p.aluc = fn;
            p.a = rs_val;
            p.b = rt_val;
            p.dest = instr[15:11];
            p.ovf_trap_en = (fn == FN_ADD) || (fn == FN_SUB);
            jr = (fn == FN_JR);
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            p.illegal = 1'b0;
            p.aluc = fn;
            p.a = {27'b0, instr[10:6]};
            p.b = rt_val;
            p.dest = instr[15:11];
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        p.illegal = 1'b0;
        p.a = rs_val;
        p.b = sx;
        p.dest = instr[20:16];
        case (op)
          OP_ADDI:  p.aluc = ALUC_ADD;
          OP_ADDIU: p.aluc = ALUC_ADDU;
          OP_SLTI:  p.aluc = ALUC_SLT;
          default:  p.aluc = ALUC_SLTU;
        endcase
        p.ovf_trap_en = (op == OP_ADDI);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        p.illegal = 1'b0;
        p.a = rs_val;
        p.b = zx;
        p.dest = instr[20:16];
        case (op)
          OP_ANDI: p.aluc = ALUC_AND;
          OP_ORI:  p.aluc = ALUC_OR;
          default: p.aluc = ALUC_XOR;
        endcase
      end
      OP_LUI: begin
        p.illegal = 1'b0;
        p.aluc = ALUC_LUI;
        p.a = zx;
        p.b = '0;
        p.dest = instr[20:16];
      end
      default: ;
    endcase
    p.wr_en = !p.illegal && !jr && (p.dest != 5'd0);
    return p;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer with registered head and synchronous flush.
// in_ready comes only from state, so there is no out_ready -> in_ready path.
module alu_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] head, skid;
  logic          acc, pop;

  assign in_ready  = !rst && (state != S_FULL);
  assign out_valid = (state != S_EMPTY);
  assign dout      = head;
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (acc) begin
          head  <= din;
          state <= S_ONE;
        end
        S_ONE: begin
          if (acc && pop) head <= din;
          else if (acc) begin
            skid  <= din;
            state <= S_FULL;
          end else if (pop) state <= S_EMPTY;
        end
        S_FULL: if (pop) begin
          head  <= skid;
          state <= S_ONE;
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-entry stage: decodes instruction + operands and presents them to the ALU
// through a skid buffer so operands are always registered.
module alu_issue
  import alu_pkg::*;
#(
  parameter int W            = 32,
  parameter int PASS_ILLEGAL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [5:0]   aluc,
  output logic [4:0]   dest,
  output logic         wr_en,
  output logic         ovf_trap_en,
  output logic         illegal
);

  alu_pl_t dec, head;
  logic    enq;

  assign dec = alu_decode(instr, rs_val, rt_val);
  // Dropped illegals still handshake upstream; they just never reach the buffer.
  assign enq = in_valid && !flush && ((PASS_ILLEGAL != 0) || !dec.illegal);

  alu_skid_buf #(.DW($bits(alu_pl_t))) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (enq),
    .in_ready  (in_ready),
    .din       (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (head)
  );

  assign a           = head.a;
  assign b           = head.b;
  assign aluc        = head.aluc;
  assign dest        = head.dest;
  assign wr_en       = head.wr_en;
  assign ovf_trap_en = head.ovf_trap_en;
  assign illegal     = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized + directed bench for alu_issue; two instances (PASS_ILLEGAL=1 and 0)
// share stimulus and are checked against a mnemonic-level queue model.
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] a, b;
    logic [5:0]  aluc;
    logic [4:0]  dest;
    logic        wr, ovf, ill;
  } exp_t;

  logic        clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] instr = 0, rs_val = 0, rt_val = 0;
  logic [1:0]  in_ready_w, out_valid_w, wr_w, ovf_w, ill_w;
  logic [31:0] a_w [2], b_w [2];
  logic [5:0]  aluc_w [2];
  logic [4:0]  dest_w [2];
  exp_t        q0 [$], q1 [$];
  int          nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  alu_issue #(.W(32), .PASS_ILLEGAL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .a(a_w[1]), .b(b_w[1]), .aluc(aluc_w[1]), .dest(dest_w[1]),
    .wr_en(wr_w[1]), .ovf_trap_en(ovf_w[1]), .illegal(ill_w[1]));

  alu_issue #(.W(32), .PASS_ILLEGAL(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .a(a_w[0]), .b(b_w[0]), .aluc(aluc_w[0]), .dest(dest_w[0]),
    .wr_en(wr_w[0]), .ovf_trap_en(ovf_w[0]), .illegal(ill_w[0]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic string mnem(input logic [31:0] ins);
    if (ins[31:26] == 6'd0) begin
      case (ins[5:0])
        6'b100000: return "add";   6'b100001: return "addu";
        6'b100010: return "sub";   6'b100011: return "subu";
        6'b100100: return "and";   6'b100101: return "or";
        6'b100110: return "xor";   6'b100111: return "nor";
        6'b101010: return "slt";   6'b101011: return "sltu";
        6'b000100: return "sllv";  6'b000110: return "srlv";
        6'b000111: return "srav";  6'b001000: return "jr";
        6'b000000: return "sll";   6'b000010: return "srl";
        6'b000011: return "sra";
        default:   return "ill";
      endcase
    end
    case (ins[31:26])
      6'd8:  return "addi";  6'd9:  return "addiu";
      6'd10: return "slti";  6'd11: return "sltiu";
      6'd12: return "andi";  6'd13: return "ori";
      6'd14: return "xori";  6'd15: return "lui";
      default: return "ill";
    endcase
  endfunction

  function automatic logic [5:0] code_of(input string m);
    case (m)
      "add", "addi":   return 6'b100000;
      "addu", "addiu": return 6'b100001;
      "sub":           return 6'b100010;
      "subu":          return 6'b100011;
      "and", "andi":   return 6'b100100;
      "or", "ori":     return 6'b100101;
      "xor", "xori":   return 6'b100110;
      "nor":           return 6'b100111;
      "slt", "slti":   return 6'b101010;
      "sltu", "sltiu": return 6'b101011;
      "sllv":          return 6'b000100;
      "srlv":          return 6'b000110;
      "srav":          return 6'b000111;
      "jr":            return 6'b001000;
      "sll":           return 6'b000000;
      "srl":           return 6'b000010;
      "sra":           return 6'b000011;
      "lui":           return 6'b001111;
      default:         return 6'b100001;
    endcase
  endfunction

  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t  e;
    string m;
    logic [31:0] imm_s, imm_z;
    m = mnem(ins);
    imm_s = 32'(signed'(ins[15:0]));
    imm_z = 32'(ins[15:0]);
    e = '0;
    e.aluc = code_of(m);
    if (m == "ill") begin
      e.ill = 1;
      return e;
    end
    if (m == "sll" || m == "srl" || m == "sra") begin
      e.a = 32'(ins[10:6]); e.b = rt; e.dest = ins[15:11];
    end else if (ins[31:26] == 0) begin
      e.a = rs; e.b = rt; e.dest = ins[15:11];
    end else if (m == "lui") begin
      e.a = imm_z; e.b = 0; e.dest = ins[20:16];
    end else if (m == "andi" || m == "ori" || m == "xori") begin
      e.a = rs; e.b = imm_z; e.dest = ins[20:16];
    end else begin
      e.a = rs; e.b = imm_s; e.dest = ins[20:16];
    end
    e.ovf = (m == "add" || m == "sub" || m == "addi");
    e.wr  = (m != "jr") && (e.dest != 0);
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0]  fns [17];
    logic [31:0] w;
    int          r;
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
            6'h04, 6'h06, 6'h07, 6'h08, 6'h00, 6'h02, 6'h03};
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r <= 3) begin
      w[31:26] = 0;
      if (r != 0) w[5:0] = fns[$urandom_range(0, 16)];
    end else if (r <= 8) w[31:26] = 6'($urandom_range(8, 15));
    return w;
  endfunction

  task automatic check_one(input int k);
    exp_t e;
    int   n;
    n = (k == 1) ? q1.size() : q0.size();
    chk($sformatf("out_valid%0d", k), 32'(out_valid_w[k]), 32'(n > 0));
    chk($sformatf("in_ready%0d", k), 32'(in_ready_w[k]), 32'(!rst && n < 2));
    if (n > 0) begin
      e = (k == 1) ? q1[0] : q0[0];
      chk($sformatf("a%0d", k), a_w[k], e.a);
      chk($sformatf("b%0d", k), b_w[k], e.b);
      chk($sformatf("aluc%0d", k), 32'(aluc_w[k]), 32'(e.aluc));
      chk($sformatf("dest%0d", k), 32'(dest_w[k]), 32'(e.dest));
      chk($sformatf("ctl%0d", k), {29'b0, wr_w[k], ovf_w[k], ill_w[k]}, {29'b0, e.wr, e.ovf, e.ill});
    end
  endtask

  // Drive one cycle, advance the model at the edge, check on the falling edge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] rsv,
                      input logic [31:0] rtv, input logic fl, input logic ordy, input logic r);
    exp_t e;
    bit   acc1, acc0;
    rst = r; in_valid = iv; instr = ins; rs_val = rsv; rt_val = rtv; flush = fl; out_ready = ordy;
    @(posedge clk);
    e = ref_model(ins, rsv, rtv);
    if (r || fl) begin
      q1.delete(); q0.delete();
    end else begin
      acc1 = iv && q1.size() < 2;
      acc0 = iv && q0.size() < 2;
      if (ordy && q1.size() > 0) void'(q1.pop_front());
      if (ordy && q0.size() > 0) void'(q0.pop_front());
      if (acc1) q1.push_back(e);
      if (acc0 && !e.ill) q0.push_back(e);
    end
    @(negedge clk);
    check_one(1);
    check_one(0);
  endtask

  initial begin
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_payload", a_w[1] | b_w[1] | 32'(aluc_w[1]) | 32'(dest_w[1]), 0);
    chk("rst_ctl", 32'({wr_w[1], ovf_w[1], ill_w[1]}), 0);
    step(0, 0, 0, 0, 0, 0, 0);  // first cycle after reset: in_ready=1

    step(1, 32'h2128FFFF, 5, 0, 0, 1, 0);
    chk("addi_a", a_w[1], 5);
    chk("addi_b", b_w[1], 32'hFFFFFFFF);
    chk("addi_aluc", 32'(aluc_w[1]), 32'b100000);
    chk("addi_dest", 32'(dest_w[1]), 8);
    chk("addi_wr_ovf", 32'({wr_w[1], ovf_w[1]}), 3);
    step(1, 32'h00031100, 0, 1, 0, 1, 0);
    chk("sll_a", a_w[1], 4);
    chk("sll_dest", 32'(dest_w[1]), 2);
    step(1, 32'h3C041234, 0, 0, 0, 1, 0);
    chk("lui_a", a_w[1], 32'h1234);
    chk("lui_ovf", 32'(ovf_w[1]), 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Backpressure: A, B fill the buffer; C is refused until FULL clears.
    step(1, 32'h00221820, 1, 2, 0, 0, 0);
    step(1, 32'h00221822, 3, 4, 0, 0, 0);
    chk("full_in_ready", 32'(in_ready_w[1]), 0);
    step(1, 32'h34650077, 9, 0, 0, 0, 0);
    step(1, 32'h34650077, 9, 0, 0, 1, 0);
    chk("drain_b_aluc", 32'(aluc_w[1]), 32'b100010);
    step(1, 32'h34650077, 9, 0, 0, 1, 0);
    chk("third_b", b_w[1], 32'h77);
    step(0, 0, 0, 0, 0, 1, 0);

    // Flush while FULL with an offer the same cycle.
    step(1, 32'h00221820, 1, 2, 0, 0, 0);
    step(1, 32'h00221821, 1, 2, 0, 0, 0);
    step(1, 32'h24050001, 7, 0, 1, 0, 0);
    chk("flush_ov", 32'(out_valid_w[1]), 0);
    chk("flush_ir", 32'(in_ready_w[1]), 1);
    step(0, 0, 0, 0, 0, 1, 0);

    // Illegal opcode: passed by dut1, dropped by dut0.
    step(1, 32'hFC000000, 3, 4, 0, 0, 0);
    chk("ill_flag", 32'(ill_w[1]), 1);
    chk("ill_aluc", 32'(aluc_w[1]), 32'b100001);
    chk("ill_drop", 32'(out_valid_w[0]), 0);
    step(0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, rnd_instr(), $urandom, $urandom,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Execute-entry stage directly upstream of the combinational ALU (module alu).
- Decodes a 32-bit MIPS instruction plus register-file operands into ALU inputs a, b, aluc and writeback control.
- Delivers them through a 2-entry valid/ready skid buffer, so the ALU always sees stable, registered operands.
- Consumers: alu (operands) and the EX/MEM register (writeback control).

Parameters:
- W, 32, operand width; only 32 is supported.
- PASS_ILLEGAL, 1, 1 = issue undecodable instructions with illegal=1; 0 = accept and silently drop them.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- rs_val  in  W  rs register value
- rt_val  in  W  rt register value
- flush  in  1  synchronous kill of all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  ALU/EX-MEM consumes head
- a  out  W  ALU operand a
- b  out  W  ALU operand b
- aluc  out  6  ALU control code
- dest  out  5  writeback register
- wr_en  out  1  result is written back
- ovf_trap_en  out  1  overflow must trap (ADD, SUB, ADDI)
- illegal  out  1  undecodable instruction

Behaviour:
- Reset: state EMPTY; out_valid=0; a, b, aluc, dest, wr_en, ovf_trap_en, illegal all 0; in_ready=0 while rst=1 and 1 on the first cycle after.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- States:
  - EMPTY: accept → ONE.
  - ONE: accept & !pop → FULL; pop & !accept → EMPTY; both → ONE.
  - FULL: pop → ONE; no accept possible.
- in_ready = !rst && state != FULL. It depends only on registered state, with no combinational path from out_ready.
- Latency: an instruction accepted at edge N is on the outputs with out_valid=1 after edge N (one cycle). Order is strict FIFO.
- Output payload stays stable while out_valid && !out_ready.
- flush: next state EMPTY, out_valid=0. An instruction offered the same cycle is discarded even if in_ready=1. flush wins over pop and accept.
- rst mid-operation: identical to reset; buffered entries are lost.
- Decode, R-type (opcode 0): aluc = funct for ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLLV 000100, SRLV 000110, SRAV 000111, JR 001000.
  - a = rs_val, b = rt_val, dest = rd.
  - SLL 000000, SRL 000010, SRA 000011: a = {27'b0, shamt}, b = rt_val.
  - JR: wr_en=0.
- Decode, I-type (dest = rt, a = rs_val):
  - ADDI 001000 → ADD, sign-extended imm.
  - ADDIU 001001 → ADDU, sign-extended.
  - SLTI 001010 → SLT, sign-extended.
  - SLTIU 001011 → SLTU, sign-extended then unsigned compare.
  - ANDI 001100 → AND, zero-extended.
  - ORI 001101 → OR, zero-extended.
  - XORI 001110 → XOR, zero-extended.
  - LUI 001111 → aluc 001111, a = {16'b0, imm}, b = 0.
- wr_en = 1 for all legal non-JR instructions unless dest = 0.
- Illegal (any other opcode/funct): aluc=100001, a=b=0, wr_en=0, illegal=1. With PASS_ILLEGAL=0 the instruction is accepted (in_ready honoured) but never enqueued.

Decomposition:
- Package alu_pkg:
  - aluc constants.
  - opcode/funct constants.
  - payload struct {a, b, aluc, dest, wr_en, ovf_trap_en, illegal}.
  - pure decode function.
- Sub-module alu_skid_buf: generic 2-entry valid/ready skid buffer with flush, parameterised on payload width.
- alu_issue = decode function + alu_skid_buf.

Test Plan:
- Reset then ADDI $t0,$t1,-1 (instr 0x2128FFFF, rs_val=5), out_ready=1 → next cycle a=5, b=0xFFFFFFFF, aluc=100000, dest=8, wr_en=1, ovf_trap_en=1.
- SLL $2,$3,4 (0x00031100, rt_val=0x1) → a=4, b=1, aluc=000000, dest=2.
- LUI $4,0x1234 (0x3C041234) → a=0x00001234, b=0, aluc=001111, dest=4, ovf_trap_en=0.
- Backpressure:
  - Hold out_ready=0 and offer 3 back-to-back instructions → first two accepted, in_ready=0 on the third.
  - Release out_ready → outputs drain in order over 2 cycles; third accepted the cycle after FULL clears.
- flush while FULL, with in_valid=1 the same cycle → out_valid=0 the next cycle, the offered instruction never appears, in_ready=1.
- Illegal opcode 0x3F: PASS_ILLEGAL=1 → illegal=1, aluc=100001, wr_en=0; PASS_ILLEGAL=0 → accepted, out_valid stays 0.
